// File: rtl/rename_ctrl.sv
// Register rename scoreboard: per-register busy bit and producer ROB tag, issue handshake,
// commit write-back into the architectural register file, and a two-cycle flush/recover sequence.
module rename_ctrl #(
  parameter int REG_S     = 32,
  parameter int REG_ADD_W = 5,
  parameter int ROB_ADD_W = 4,
  parameter int REG_DAT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iIS_Valid,
  output logic                 oIS_Ready,
  input  logic [REG_ADD_W-1:0] iIS_Rs1,
  input  logic [REG_ADD_W-1:0] iIS_Rs2,
  input  logic                 iIS_EnRd,
  input  logic [REG_ADD_W-1:0] iIS_Rd,
  input  logic [ROB_ADD_W-1:0] iROB_Qn,
  input  logic                 iROB_Full,
  output logic                 oRN_Valid,
  output logic                 oRN_Rdy1,
  output logic [ROB_ADD_W-1:0] oRN_Q1,
  output logic                 oRN_Rdy2,
  output logic [ROB_ADD_W-1:0] oRN_Q2,
  input  logic                 iCM_En,
  input  logic [REG_ADD_W-1:0] iCM_Rd,
  input  logic [ROB_ADD_W-1:0] iCM_Tag,
  input  logic [REG_DAT_W-1:0] iCM_Vd,
  output logic                 oRF_We,
  output logic [REG_ADD_W-1:0] oRF_Wa,
  output logic [REG_DAT_W-1:0] oRF_Wd,
  input  logic                 iFlush,
  output logic [REG_ADD_W:0]   oBusyCnt
);

  localparam int CNT_W = REG_ADD_W + 1;

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

  state_t               state, state_nxt;
  logic [REG_S-1:0]     busy;
  logic [ROB_ADD_W-1:0] tag [REG_S];

  logic                 accept, ren, ren_new, cm_wr, cm_clr;
  logic                 rdy1, rdy2;
  logic [ROB_ADD_W-1:0] q1, q2;

  assign oIS_Ready = en && (state == RUN) && !iROB_Full && !iFlush;
  assign accept    = iIS_Valid && oIS_Ready;
  assign ren       = accept && iIS_EnRd && (iIS_Rd != '0);
  assign ren_new   = ren && !busy[iIS_Rd];
  assign cm_wr     = iCM_En && (iCM_Rd != '0);
  // A rename of the committing register in the same cycle keeps it busy under the new tag.
  assign cm_clr    = cm_wr && busy[iCM_Rd] && (tag[iCM_Rd] == iCM_Tag)
                     && !(ren && (iIS_Rd == iCM_Rd));

  // Sources see the pre-edge mapping; a matching commit this cycle bypasses to ready.
  assign rdy1 = (iIS_Rs1 == '0) || !busy[iIS_Rs1]
                || (iCM_En && (iCM_Rd == iIS_Rs1) && (iCM_Tag == tag[iIS_Rs1]));
  assign rdy2 = (iIS_Rs2 == '0) || !busy[iIS_Rs2]
                || (iCM_En && (iCM_Rd == iIS_Rs2) && (iCM_Tag == tag[iIS_Rs2]));
  assign q1   = rdy1 ? '0 : tag[iIS_Rs1];
  assign q2   = rdy2 ? '0 : tag[iIS_Rs2];

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (iFlush) begin
      state_nxt = FLUSH;
    end else begin
      unique case (state)
        FLUSH:   state_nxt = RECOVER;
        RECOVER: state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the tag array is small flop storage whose reset value is observable, so it is reset too.
    if (rst) begin
      state     <= RUN;
      busy      <= '0;
      for (int i = 0; i < REG_S; i++) tag[i] <= '0;
      oRN_Valid <= 1'b0;
      oRN_Rdy1  <= 1'b0;
      oRN_Q1    <= '0;
      oRN_Rdy2  <= 1'b0;
      oRN_Q2    <= '0;
      oRF_We    <= 1'b0;
      oRF_Wa    <= '0;
      oRF_Wd    <= '0;
      oBusyCnt  <= '0;
    end else if (en) begin
      state     <= state_nxt;
      oRN_Valid <= accept;
      if (accept) begin
        oRN_Rdy1 <= rdy1;
        oRN_Q1   <= q1;
        oRN_Rdy2 <= rdy2;
        oRN_Q2   <= q2;
      end
      oRF_We <= cm_wr;
      if (cm_wr) begin
        oRF_Wa <= iCM_Rd;
        oRF_Wd <= iCM_Vd;
      end
      if (iFlush) begin
        busy     <= '0;
        for (int i = 0; i < REG_S; i++) tag[i] <= '0;
        oBusyCnt <= '0;
      end else begin
        if (cm_clr) busy[iCM_Rd] <= 1'b0;
        if (ren) begin
          busy[iIS_Rd] <= 1'b1;
          tag[iIS_Rd]  <= iROB_Qn;
        end
        unique case ({ren_new, cm_clr})
          2'b10:   oBusyCnt <= oBusyCnt + CNT_W'(1);
          2'b01:   oBusyCnt <= oBusyCnt - CNT_W'(1);
          default: oBusyCnt <= oBusyCnt;
        endcase
      end
    end
  end

endmodule
